matmul_result_drain: RTL and testbench
======================================

# matmul_result_drain

Downstream stage of the HIR matmul kernel: captures the kernel's result write port (`v2_addr`, `v2_wr_en`, `v2_wr_data`) into an internal result buffer. Once every expected result address has been written, it streams the results out in ascending address order over a valid/ready interface. It then returns to idle, ready for the next kernel launch. It is armed by the same `tstart` pulse that launches the kernel.

## Interface
Parameters:
- `ADDR_W`, default 8: width of the kernel result address.
- `DATA_W`, default 32: result word width.
- `NUM_RESULTS`, default 256: distinct addresses expected per run. Legal range is 1..2^ADDR_W.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tstart`  in  1  one-cycle start pulse, shared with the kernel; arms capture.
- `v2_addr`  in  ADDR_W  kernel write address.
- `v2_wr_en`  in  1  kernel write strobe.
- `v2_wr_data`  in  DATA_W  kernel write data.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_addr`  out  ADDR_W  result address of the output word.
- `out_data`  out  DATA_W  result value.
- `out_last`  out  1  high with the word at address NUM_RESULTS-1.
- `busy`  out  1  high in CAPTURE or DRAIN.
- `done`  out  1  one-cycle pulse after the last word handshake.
- `err`  out  1  sticky protocol-error flag; cleared by an accepted `tstart`.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `tstart`=1 → CAPTURE. This clears the written-bitmap, the distinct-write count and `err`.
  - `v2_wr_en` in IDLE: write dropped, `err` set.
- CAPTURE, on `v2_wr_en`=1:
  - `v2_addr` < NUM_RESULTS: data is stored at `v2_addr`.
    - Bitmap bit clear: set it and increment the count.
    - Bitmap bit already set: data overwritten, count unchanged, `err` set.
  - `v2_addr` ≥ NUM_RESULTS: write dropped, `err` set.
  - The edge that accepts the NUM_RESULTS-th distinct write moves the state to DRAIN.
  - `tstart` in CAPTURE: ignored.
- DRAIN:
  - Sequential buffer read of addresses 0..NUM_RESULTS-1. Each word is presented with `out_addr` = its address.
  - A word transfers when `out_valid` && `out_ready`.
  - `out_valid`, `out_addr`, `out_data` and `out_last` hold stable until the word is accepted.
  - Writes in DRAIN: dropped, `err` set. `tstart` in DRAIN: ignored.
  - After the handshake of the `out_last` word: state → IDLE, `done`=1 for one cycle.
- Simultaneous `tstart` and `v2_wr_en` in IDLE: the transition to CAPTURE wins and the write is dropped without setting `err`. The kernel cannot write in its start cycle.
- Reset mid-operation: state returns to IDLE immediately. Bitmap and count are cleared. Buffer contents are don't-care.

## Timing
- Reset values: `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, `err`=0. State is IDLE.
- `busy` rises on the edge after `tstart` is sampled and falls together with the `done` pulse.
- The result buffer has a synchronous read with 1-cycle latency.
- First `out_valid`: 2 cycles after entering DRAIN (one read-issue cycle, one data cycle).
- Sustained throughput is one word per cycle while `out_ready` is held high, with no bubbles.
- A 2-entry output skid buffer absorbs `out_ready` deassertion. The buffer read advances only when a skid slot will be free.
- `out_ready` may toggle arbitrarily. No word is lost or duplicated.
- Capture accepts a write every cycle. Back-to-back writes to the same address are counted once.
- `done` is asserted on the edge following the final handshake.

## Structure
- Shared package `matmul_pkg` holds:
  - the state enum `drain_state_e` (IDLE, CAPTURE, DRAIN);
  - default `ADDR_W`/`DATA_W` localparams shared with the kernel testbenches.
- Sub-module `result_ram`: simple dual-port RAM, 2^ADDR_W × DATA_W, with a write port and a synchronous-read port (1-cycle latency). It has no reset.
- The bitmap, counter, FSM and skid buffer live in the top module.

## Test plan
- Full run, in order: reset, `tstart`, then writes addr k with data 3k+1 for k=0..255 on consecutive cycles, `out_ready`=1.
  - 256 words out with `out_data`=3k+1 and `out_addr`=k.
  - `out_last` only on k=255, one `done` pulse, `err`=0.
- Reverse order with duplicate, NUM_RESULTS=16:
  - Writes addr 15..0, plus addr 5 rewritten with 0xDEAD before the last write.
  - Drain emits 0xDEAD at addr 5 and `err`=1.
  - Transition to DRAIN occurs only after 16 distinct addresses.
- Backpressure: toggle `out_ready` pseudo-randomly during drain.
  - Every word appears exactly once in order.
  - Outputs are stable while `out_valid`=1 && `out_ready`=0.
- Stray writes:
  - A write in IDLE sets `err` and is not stored.
  - A write to addr 200 with NUM_RESULTS=16 sets `err` and does not advance the count.
  - The next `tstart` clears `err`.
- Reset mid-CAPTURE after 10 writes:
  - Outputs return to reset values immediately.
  - A new `tstart` + 16 writes drains 16 fresh values and no stale bitmap bits.
- Back-to-back runs: assert `tstart` in the cycle after `done`. The second run captures and drains correctly.

Source files
------------

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and default widths for the matmul kernel and its result drain
package matmul_pkg;

  localparam int MM_ADDR_W = 8;
  localparam int MM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } drain_state_e;

endpackage

// File: rtl/result_ram.sv
// rtl/result_ram.sv - simple dual-port result buffer, one write port, synchronous read port
module result_ram
  import matmul_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/matmul_result_drain.sv
// rtl/matmul_result_drain.sv - captures kernel result writes, then streams them out in address order
module matmul_result_drain
  import matmul_pkg::*;
#(
  parameter int ADDR_W      = MM_ADDR_W,
  parameter int DATA_W      = MM_DATA_W,
  parameter int NUM_RESULTS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tstart,
  input  logic [ADDR_W-1:0] v2_addr,
  input  logic              v2_wr_en,
  input  logic [DATA_W-1:0] v2_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_R     = (ADDR_W+1)'(NUM_RESULTS);
  localparam logic [ADDR_W:0] NUM_M1    = (ADDR_W+1)'(NUM_RESULTS - 1);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_RESULTS - 1);

  drain_state_e state, state_nxt;

  logic [DEPTH-1:0]  written;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W:0]   issue_cnt;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data;

  logic [1:0]        occ;
  logic [ADDR_W-1:0] head_addr, tail_addr;
  logic [DATA_W-1:0] head_data, tail_data;

  logic in_range, start_ok, cap_wr, ram_we, first_wr, pop, rd_issue, last_pop, bad_wr;

  assign in_range = ({1'b0, v2_addr} < NUM_R);
  assign start_ok = (state == IDLE) && tstart;
  assign cap_wr   = (state == CAPTURE) && v2_wr_en;
  assign ram_we   = cap_wr && in_range;
  assign first_wr = ram_we && !written[v2_addr];
  assign pop      = out_valid && out_ready;
  assign last_pop = pop && out_last;

  // Issue a read only if the skid buffer can still hold it after this cycle's pop.
  assign rd_issue = (state == DRAIN) && (issue_cnt < NUM_R) &&
                    (({1'b0, occ} + {2'b00, rd_valid}) < (3'd2 + {2'b00, pop}));

  // tstart in IDLE swallows a same-cycle write without flagging it.
  assign bad_wr = ((state == IDLE) && v2_wr_en && !tstart) ||
                  (cap_wr && (!in_range || written[v2_addr])) ||
                  ((state == DRAIN) && v2_wr_en);

  assign out_valid = (occ != 2'd0);
  assign out_addr  = head_addr;
  assign out_data  = head_data;
  assign out_last  = out_valid && (head_addr == LAST_ADDR);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tstart) state_nxt = CAPTURE;
      CAPTURE: if (first_wr && (wr_count == NUM_M1)) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written  <= '0;
      wr_count <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last_pop;
      if (start_ok) begin
        written  <= '0;
        wr_count <= '0;
        err      <= 1'b0;
      end else begin
        if (first_wr) begin
          written[v2_addr] <= 1'b1;
          wr_count         <= wr_count + ONE;
        end
        if (bad_wr) err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      rd_valid  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_valid <= rd_issue;
      if (start_ok) begin
        issue_cnt <= '0;
      end else if (rd_issue) begin
        issue_cnt <= issue_cnt + ONE;
        rd_addr_q <= issue_cnt[ADDR_W-1:0];
      end
    end
  end

  // Two-entry skid: head drives the outputs and only moves on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      head_addr <= '0;
      head_data <= '0;
      tail_addr <= '0;
      tail_data <= '0;
    end else begin
      case (occ)
        2'd0: begin
          if (rd_valid) begin
            head_addr <= rd_addr_q;
            head_data <= rd_data;
            occ       <= 2'd1;
          end
        end
        2'd1: begin
          if (rd_valid && pop) begin
            head_addr <= rd_addr_q;
            head_data <= rd_data;
          end else if (rd_valid) begin
            tail_addr <= rd_addr_q;
            tail_data <= rd_data;
            occ       <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_addr <= tail_addr;
            head_data <= tail_data;
            occ       <= 2'd1;
          end
        end
      endcase
    end
  end

  result_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (v2_addr),
    .wr_data (v2_wr_data),
    .rd_en   (rd_issue),
    .rd_addr (issue_cnt[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_matmul_result_drain.sv
// tb/tb_matmul_result_drain.sv - scoreboard bench for matmul_result_drain (NUM_RESULTS 256 and 16)
`timescale 1ns/1ps
module tb_matmul_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  tstart, v2_wr_en, out_valid, out_ready, out_last, busy, done, err;
  logic [7:0]  v2_addr [2];
  logic [7:0]  out_addr [2];
  logic [31:0] v2_wr_data [2];
  logic [31:0] out_data [2];

  matmul_result_drain #(.ADDR_W(8), .DATA_W(32), .NUM_RESULTS(256)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .tstart(tstart[0]), .v2_addr(v2_addr[0]), .v2_wr_en(v2_wr_en[0]),
    .v2_wr_data(v2_wr_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_addr(out_addr[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  matmul_result_drain #(.ADDR_W(8), .DATA_W(32), .NUM_RESULTS(16)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .tstart(tstart[1]), .v2_addr(v2_addr[1]), .v2_wr_en(v2_wr_en[1]),
    .v2_wr_data(v2_wr_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_addr(out_addr[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] v;
  } exp_t;

  int          n_checks;
  int          n_errors;
  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] exp_mem [2][256];
  bit          rand_rdy [2];
  int          done_cnt [2];
  logic [41:0] prev_out [2];
  bit          prev_stall [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nr(input int d);
    return (d == 0) ? 256 : 16;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d);
    tstart[d] = 1'b1;
    cyc();
    tstart[d] = 1'b0;
  endtask

  task automatic write(input int d, input int a, input logic [31:0] v, input bit store);
    v2_addr[d]    = 8'(a);
    v2_wr_data[d] = v;
    v2_wr_en[d]   = 1'b1;
    if (store) exp_mem[d][a] = v;
    cyc();
    v2_wr_en[d] = 1'b0;
  endtask

  task automatic push_expected(input int d);
    for (int k = 0; k < nr(d); k++) begin
      exp_t e;
      e.a = 8'(k);
      e.v = exp_mem[d][k];
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  task automatic wait_done(input int d, input string tag);
    int c0;
    int n;
    c0 = done_cnt[d];
    n  = 0;
    while (!done[d] && n < 2000) begin
      cyc();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done[d]), 64'(1));
    repeat (3) cyc();
    check({tag, "_done_pulses"}, 64'(done_cnt[d] - c0), 64'(1));
    check({tag, "_sb_empty"}, 64'((d == 0) ? sb0.size() : sb1.size()), 64'(0));
    check({tag, "_idle"}, 64'(busy[d]), 64'(0));
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_ctrl"}, 64'({out_valid[d], out_last[d], busy[d], done[d], err[d]}), 64'(0));
    check({tag, "_addr"}, 64'(out_addr[d]), 64'(0));
    check({tag, "_data"}, 64'(out_data[d]), 64'(0));
  endtask

  initial begin
    out_ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        out_ready[d] = rand_rdy[d] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Handshakes are judged at negedge; out_ready only changes just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic [41:0] cur;
        exp_t        e;
        cur = {out_valid[d], out_last[d], out_addr[d], out_data[d]};
        if (prev_stall[d]) check("hold_stable", 64'(cur), 64'(prev_out[d]));
        if (done[d]) done_cnt[d]++;
        if (out_valid[d] && out_ready[d]) begin
          if ((d == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
            check("extra_word", 64'(1), 64'(0));
          end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            check("out_addr", 64'(out_addr[d]), 64'(e.a));
            check("out_data", 64'(out_data[d]), 64'(e.v));
            check("out_last", 64'(out_last[d]), 64'(e.a == 8'(nr(d) - 1)));
          end
        end
        prev_stall[d] = out_valid[d] && !out_ready[d];
        prev_out[d]   = cur;
      end
    end else begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    tstart        = 2'b00;
    v2_wr_en      = 2'b00;
    v2_addr[0]    = '0;
    v2_addr[1]    = '0;
    v2_wr_data[0] = '0;
    v2_wr_data[1] = '0;
    rand_rdy[0]   = 1'b0;
    rand_rdy[1]   = 1'b0;
    done_cnt[0]   = 0;
    done_cnt[1]   = 0;
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;
    repeat (3) cyc();
    check_reset_outputs(0, "rst0");
    check_reset_outputs(1, "rst1");
    rst_n = 1'b1;
    cyc();

    // Full 256-word run, ready held high, checks first-word latency.
    start(0);
    check("full_busy", 64'(busy[0]), 64'(1));
    for (int k = 0; k < 256; k++) write(0, k, 32'(3 * k + 1), 1'b1);
    push_expected(0);
    check("full_lat0", 64'(out_valid[0]), 64'(0));
    cyc();
    check("full_lat1", 64'(out_valid[0]), 64'(0));
    cyc();
    check("full_lat2", 64'(out_valid[0]), 64'(1));
    wait_done(0, "full");
    check("full_err", 64'(err[0]), 64'(0));

    // Reverse order with a duplicate, random backpressure.
    rand_rdy[1] = 1'b1;
    start(1);
    for (int k = 15; k >= 1; k--) write(1, k, 32'h100 + 32'(k), 1'b1);
    write(1, 5, 32'hDEAD, 1'b1);
    repeat (3) cyc();
    check("rev_not_drain", 64'(out_valid[1]), 64'(0));
    check("rev_busy", 64'(busy[1]), 64'(1));
    write(1, 0, 32'h100, 1'b1);
    push_expected(1);
    wait_done(1, "rev");
    check("rev_err", 64'(err[1]), 64'(1));

    // Stray writes: idle write, out-of-range write.
    write(1, 3, 32'hBAD, 1'b0);
    check("idle_wr_err", 64'(err[1]), 64'(1));
    check("idle_wr_busy", 64'(busy[1]), 64'(0));
    start(1);
    check("start_clr_err", 64'(err[1]), 64'(0));
    write(1, 200, 32'hBAD, 1'b0);
    check("oob_err", 64'(err[1]), 64'(1));
    for (int k = 0; k < 15; k++) write(1, k, 32'h500 + 32'(k), 1'b1);
    repeat (3) cyc();
    check("oob_no_count", 64'(out_valid[1]), 64'(0));
    write(1, 15, 32'h50F, 1'b1);
    push_expected(1);
    wait_done(1, "stray");
    check("stray_err_sticky", 64'(err[1]), 64'(1));

    // Asynchronous reset mid-capture, then a clean run.
    rand_rdy[1] = 1'b0;
    start(1);
    check("rst_run_err", 64'(err[1]), 64'(0));
    for (int k = 0; k < 10; k++) write(1, k, 32'h600 + 32'(k), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1, "midrst");
    cyc();
    rst_n = 1'b1;
    cyc();
    start(1);
    for (int k = 0; k < 16; k++) write(1, k, 32'h700 + 32'(k), 1'b1);
    push_expected(1);
    wait_done(1, "postrst");
    check("postrst_err", 64'(err[1]), 64'(0));

    // Back-to-back runs: tstart in the cycle after done.
    rand_rdy[1] = 1'b1;
    start(1);
    for (int k = 0; k < 16; k++) write(1, k, 32'h800 + 32'(k), 1'b1);
    push_expected(1);
    n = 0;
    while (!done[1] && n < 2000) begin
      cyc();
      n++;
    end
    check("b2b_done1", 64'(done[1]), 64'(1));
    check("b2b_sb1_empty", 64'(sb1.size()), 64'(0));
    cyc();
    start(1);
    check("b2b_busy2", 64'(busy[1]), 64'(1));
    for (int k = 0; k < 16; k++) write(1, k, 32'h900 + 32'(k), 1'b1);
    push_expected(1);
    wait_done(1, "b2b2");
    check("b2b2_err", 64'(err[1]), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
